// File: rtl/rob_commit_unit_if.sv
// rtl/rob_commit_unit_if.sv - ROB entry type and the commit-unit handshake bundle
package rob_pkg;
    localparam int ROB_ENTRIES   = 32;
    localparam int ADDR_BITS     = 64;
    localparam int PHYS_REG_BITS = 7;

    typedef struct packed {
        logic                     done;
        logic                     exc;
        logic                     mispred;
        logic [ADDR_BITS-1:0]     pc;
        logic [ADDR_BITS-1:0]     target_pc;
        logic                     has_dest;
        logic [4:0]               arch_rd;
        logic [PHYS_REG_BITS-1:0] phys_rd;
        logic [PHYS_REG_BITS-1:0] old_phys_rd;
    } rob_entry;
endpackage

interface rob_commit_unit_if #(
    parameter int ADDR_BITS     = 64,
    parameter int COMMIT_WIDTH  = 4,
    parameter int ROB_ENTRIES   = rob_pkg::ROB_ENTRIES,
    parameter int PHYS_REG_BITS = 7
);
    rob_pkg::rob_entry [COMMIT_WIDTH-1:0]        head_in;
    logic [$clog2(ROB_ENTRIES+1)-1:0]            rob_size_in;
    logic                                        commit_ready_in;
    logic [$clog2(COMMIT_WIDTH+1)-1:0]           deq_out;
    logic [COMMIT_WIDTH-1:0]                     retire_valid_out;
    logic [5*COMMIT_WIDTH-1:0]                   retire_arch_rd_out;
    logic [PHYS_REG_BITS*COMMIT_WIDTH-1:0]       retire_phys_rd_out;
    logic [PHYS_REG_BITS*COMMIT_WIDTH-1:0]       free_phys_out;
    logic                                        flush_out;
    logic                                        valid_pc_out;
    logic [ADDR_BITS-1:0]                        pc_out;
    logic [ADDR_BITS-1:0]                        epc_out;

    modport master (
        output head_in, rob_size_in, commit_ready_in,
        input  deq_out, retire_valid_out, retire_arch_rd_out, retire_phys_rd_out,
               free_phys_out, flush_out, valid_pc_out, pc_out, epc_out
    );

    modport slave (
        input  head_in, rob_size_in, commit_ready_in,
        output deq_out, retire_valid_out, retire_arch_rd_out, retire_phys_rd_out,
               free_phys_out, flush_out, valid_pc_out, pc_out, epc_out
    );
endinterface

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - retires the complete in-order ROB prefix and handles flush/recovery
module rob_commit_unit #(
    parameter int              ADDR_BITS      = 64,
    parameter int              COMMIT_WIDTH   = 4,
    parameter int              ROB_ENTRIES    = rob_pkg::ROB_ENTRIES,
    parameter int              PHYS_REG_BITS  = 7,
    parameter int              RECOVER_CYCLES = 2,
    parameter logic [ADDR_BITS-1:0] EXC_VECTOR = 64'h0000_0000_0000_1000
) (
    input logic              clk_in,
    input logic              rst_in,
    rob_commit_unit_if.slave bus
);
    localparam int SZ_W  = $clog2(ROB_ENTRIES+1);
    localparam int DQ_W  = $clog2(COMMIT_WIDTH+1);
    localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

    state_t               state;
    logic [CNT_W-1:0]     rec_cnt;
    logic [DQ_W-1:0]      n_retire;
    logic                 ev_exc;
    logic                 ev_mis;
    logic [ADDR_BITS-1:0] ev_pc;
    logic [ADDR_BITS-1:0] ev_target;

    // Scan stops at the first slot that is out of range, not done, or carries an event;
    // the short-circuit ordering keeps X in unused slots from reaching any output.
    always_comb begin
        logic scan;
        scan      = (state == RUN) && bus.commit_ready_in && !rst_in;
        n_retire  = '0;
        ev_exc    = 1'b0;
        ev_mis    = 1'b0;
        ev_pc     = '0;
        ev_target = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (scan && (SZ_W'(i) < bus.rob_size_in) && bus.head_in[i].done) begin
                if (bus.head_in[i].exc) begin
                    ev_exc = 1'b1;
                    ev_pc  = bus.head_in[i].pc;
                    scan   = 1'b0;
                end else begin
                    n_retire = DQ_W'(i + 1);
                    if (bus.head_in[i].mispred) begin
                        ev_mis    = 1'b1;
                        ev_target = bus.head_in[i].target_pc;
                        scan      = 1'b0;
                    end
                end
            end else begin
                scan = 1'b0;
            end
        end
    end

    always_comb begin
        logic take;
        bus.deq_out            = n_retire;
        bus.retire_valid_out   = '0;
        bus.retire_arch_rd_out = '0;
        bus.retire_phys_rd_out = '0;
        bus.free_phys_out      = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            take = (DQ_W'(i) < n_retire);
            bus.retire_valid_out[i] = take && bus.head_in[i].has_dest;
            bus.retire_arch_rd_out[i*5 +: 5] = take ? bus.head_in[i].arch_rd : 5'd0;
            bus.retire_phys_rd_out[i*PHYS_REG_BITS +: PHYS_REG_BITS] =
                take ? bus.head_in[i].phys_rd : '0;
            bus.free_phys_out[i*PHYS_REG_BITS +: PHYS_REG_BITS] =
                take ? bus.head_in[i].old_phys_rd : '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= RUN;
            rec_cnt          <= '0;
            bus.flush_out    <= 1'b0;
            bus.valid_pc_out <= 1'b0;
            bus.pc_out       <= '0;
            bus.epc_out      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ev_exc) begin
                        bus.epc_out      <= ev_pc;
                        bus.pc_out       <= EXC_VECTOR;
                        bus.flush_out    <= 1'b1;
                        bus.valid_pc_out <= 1'b1;
                        state            <= FLUSH;
                    end else if (ev_mis) begin
                        bus.pc_out       <= ev_target;
                        bus.flush_out    <= 1'b1;
                        bus.valid_pc_out <= 1'b1;
                        state            <= FLUSH;
                    end
                end
                FLUSH: begin
                    bus.flush_out    <= 1'b0;
                    bus.valid_pc_out <= 1'b0;
                    rec_cnt          <= CNT_W'(RECOVER_CYCLES - 1);
                    state            <= RECOVER;
                end
                RECOVER: begin
                    if (rec_cnt == '0) state <= RUN;
                    else               rec_cnt <= rec_cnt - 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb/tb_rob_commit_unit.sv - randomized and directed checks of rob_commit_unit against a reference model
module tb_rob_commit_unit;
    localparam int CW   = 4;
    localparam int RE   = rob_pkg::ROB_ENTRIES;
    localparam int PRB  = 7;
    localparam int AB   = 64;
    localparam int RC   = 2;
    localparam int SZW  = $clog2(RE+1);
    localparam logic [63:0] EXC = 64'h0000_0000_0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_commit_unit_if #(.ADDR_BITS(AB), .COMMIT_WIDTH(CW), .ROB_ENTRIES(RE),
                         .PHYS_REG_BITS(PRB)) bus();

    rob_commit_unit #(.ADDR_BITS(AB), .COMMIT_WIDTH(CW), .ROB_ENTRIES(RE),
                      .PHYS_REG_BITS(PRB), .RECOVER_CYCLES(RC), .EXC_VECTOR(EXC))
        dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: cycles commit remains blocked, and the expected registered outputs.
    int          blk       = 0;
    logic        exp_flush = 1'b0;
    logic [63:0] exp_pc    = '0;
    logic [63:0] exp_epc   = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill(input int size, input logic [3:0] d, input logic [3:0] e, input logic [3:0] m);
        bus.rob_size_in = SZW'(size);
        for (int i = 0; i < CW; i++) begin
            bus.head_in[i].done        = d[i];
            bus.head_in[i].exc         = e[i];
            bus.head_in[i].mispred     = m[i];
            bus.head_in[i].pc          = 64'h100 + 64'(i * 4);
            bus.head_in[i].target_pc   = 64'h3000 + 64'(i * 16);
            bus.head_in[i].has_dest    = 1'b1;
            bus.head_in[i].arch_rd     = 5'($urandom);
            bus.head_in[i].phys_rd     = PRB'($urandom);
            bus.head_in[i].old_phys_rd = PRB'($urandom);
        end
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_deq"},   64'(bus.deq_out), 64'd0);
        check_val({tag, "_rv"},    64'(bus.retire_valid_out), 64'd0);
        check_val({tag, "_flush"}, 64'(bus.flush_out), 64'd0);
        check_val({tag, "_vpc"},   64'(bus.valid_pc_out), 64'd0);
        check_val({tag, "_pc"},    bus.pc_out, 64'd0);
        check_val({tag, "_epc"},   bus.epc_out, 64'd0);
    endtask

    // Called right after inputs are driven at a negedge; checks, advances the model, waits a cycle.
    task automatic step(input string tag);
        int          n;
        int          ev;
        logic [63:0] tgt;
        logic [63:0] epc;
        logic [CW-1:0] rv;
        n = 0; ev = 0; tgt = '0; epc = '0; rv = '0;
        #1;
        if (blk == 0 && bus.commit_ready_in) begin
            for (int i = 0; i < CW; i++) begin
                if (i >= int'(bus.rob_size_in) || !bus.head_in[i].done) break;
                if (bus.head_in[i].exc) begin ev = 2; epc = bus.head_in[i].pc; break; end
                n = i + 1;
                if (bus.head_in[i].mispred) begin ev = 1; tgt = bus.head_in[i].target_pc; break; end
            end
        end
        for (int i = 0; i < n; i++) rv[i] = bus.head_in[i].has_dest;
        check_val({tag, "_deq"},   64'(bus.deq_out), 64'(n));
        check_val({tag, "_rv"},    64'(bus.retire_valid_out), 64'(rv));
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_arch%0d", tag, i), 64'(bus.retire_arch_rd_out[i*5 +: 5]),
                      64'(bus.head_in[i].arch_rd));
            check_val($sformatf("%s_phys%0d", tag, i), 64'(bus.retire_phys_rd_out[i*PRB +: PRB]),
                      64'(bus.head_in[i].phys_rd));
            check_val($sformatf("%s_free%0d", tag, i), 64'(bus.free_phys_out[i*PRB +: PRB]),
                      64'(bus.head_in[i].old_phys_rd));
        end
        check_val({tag, "_flush"}, 64'(bus.flush_out), 64'(exp_flush));
        check_val({tag, "_vpc"},   64'(bus.valid_pc_out), 64'(exp_flush));
        check_val({tag, "_pc"},    bus.pc_out, exp_pc);
        check_val({tag, "_epc"},   bus.epc_out, exp_epc);
        exp_flush = (ev != 0);
        if (ev == 1) exp_pc = tgt;
        if (ev == 2) begin exp_pc = EXC; exp_epc = epc; end
        if (ev != 0)     blk = 1 + RC;
        else if (blk > 0) blk--;
        @(negedge clk);
    endtask

    task automatic random_fill();
        int size;
        size = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, RE)) : int'($urandom_range(0, 6));
        fill(size, 4'($urandom), 4'b0, 4'b0);
        for (int i = 0; i < CW; i++) begin
            bus.head_in[i].done     = ($urandom_range(0, 9) < 8);
            bus.head_in[i].exc      = ($urandom_range(0, 11) == 0);
            bus.head_in[i].mispred  = ($urandom_range(0, 9) == 0);
            bus.head_in[i].has_dest = ($urandom_range(0, 5) != 0);
            bus.head_in[i].pc       = {$urandom, $urandom};
            bus.head_in[i].target_pc = {$urandom, $urandom};
            if (i >= size) bus.head_in[i] = 'x;
        end
        bus.commit_ready_in = ($urandom_range(0, 7) != 0);
    endtask

    initial begin
        bus.commit_ready_in = 1'b1;
        fill(0, 4'b0, 4'b0, 4'b0);
        #12;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        fill(4, 4'b1111, 4'b0000, 4'b0000);  step("all_done");
        fill(4, 4'b1011, 4'b0000, 4'b0000);  step("done_gap");

        fill(4, 4'b1111, 4'b0000, 4'b0010);
        bus.head_in[1].target_pc = 64'h2000;  step("mispred1");
        for (int k = 0; k < 4; k++) begin fill(4, 4'b1111, 4'b0, 4'b0); step("mis_rec"); end

        fill(4, 4'b1111, 4'b0100, 4'b0000);
        bus.head_in[2].pc = 64'h40;           step("exc2");
        for (int k = 0; k < 4; k++) begin fill(4, 4'b1111, 4'b0, 4'b0); step("exc_rec"); end

        fill(4, 4'b1111, 4'b0001, 4'b0001);   step("exc_mis_same");
        for (int k = 0; k < 4; k++) begin fill(4, 4'b1111, 4'b0, 4'b0); step("em_rec"); end

        bus.commit_ready_in = 1'b0;
        fill(4, 4'b1111, 4'b0000, 4'b0001);   step("not_ready");
        step("not_ready2");
        bus.commit_ready_in = 1'b1;           step("ready_up");
        for (int k = 0; k < 4; k++) begin fill(4, 4'b1111, 4'b0, 4'b0); step("rdy_rec"); end

        fill(2, 4'b1111, 4'b0000, 4'b0000);
        bus.head_in[2] = 'x; bus.head_in[3] = 'x; step("size2");
        fill(0, 4'b1111, 4'b0000, 4'b0000);   step("size0");

        fill(4, 4'b1111, 4'b0000, 4'b0001);   step("pre_rst_ev");
        fill(4, 4'b1111, 4'b0000, 4'b0000);   step("pre_rst_flush");
        #2 rst = 1'b1;
        #1 check_cleared("mid_rst");
        blk = 0; exp_flush = 1'b0; exp_pc = '0; exp_epc = '0;
        @(negedge clk);
        rst = 1'b0;
        fill(4, 4'b1111, 4'b0000, 4'b0000);   step("post_rst");

        for (int k = 0; k < 500; k++) begin
            random_fill();
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Consumer end of the reorder-buffer queue.
- Inspects the oldest COMMIT_WIDTH ROB entries each cycle and retires the in-order prefix that is complete and exception-free.
- Drives the queue's dequeue count, architectural rename-table commits and physical-register frees.
- On a mispredict or exception at the head: raises a one-cycle flush with a PC redirect, then holds commit for a recovery window.

Parameters:
ADDR_BITS, 64, PC width
COMMIT_WIDTH, 4, max retires per cycle; never exceeds the queue output width
ROB_ENTRIES, rob_pkg::ROB_ENTRIES, ROB depth (sizes rob_size_in)
PHYS_REG_BITS, 7, physical register index width
RECOVER_CYCLES, 2, cycles commit stays blocked after flush (>=1)
EXC_VECTOR, 64'h0000_0000_0000_1000, trap handler PC

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
head_in  input  rob_entry[COMMIT_WIDTH]  oldest entries; slot 0 = ROB head; fields used: done, exc, mispred, pc, target_pc, has_dest, arch_rd[5], phys_rd, old_phys_rd
rob_size_in  input  $clog2(ROB_ENTRIES+1)  valid entries in the ROB
commit_ready_in  input  1  downstream (free list/RAT) can accept retires this cycle
deq_out  output  $clog2(COMMIT_WIDTH+1)  entries to pop this cycle (combinational)
retire_valid_out  output  COMMIT_WIDTH  per-slot retire strobe (combinational)
retire_arch_rd_out  output  5*COMMIT_WIDTH  arch dest per slot
retire_phys_rd_out  output  PHYS_REG_BITS*COMMIT_WIDTH  new mapping per slot
free_phys_out  output  PHYS_REG_BITS*COMMIT_WIDTH  old mapping to free per slot
flush_out  output  1  pipeline/ROB flush pulse (registered)
valid_pc_out  output  1  pc_out valid; same cycle as flush_out (registered)
pc_out  output  ADDR_BITS  redirect PC (registered)
epc_out  output  ADDR_BITS  PC of last excepting instruction (registered, held)

Behaviour:
- Reset (async, immediate): state=RUN, flush_out=0, valid_pc_out=0, pc_out=0, epc_out=0, recovery counter=0. Combinational outputs are 0 while rst_in is high.
- States: RUN, FLUSH, RECOVER.
- RUN, slot scan: slot i is eligible iff i < rob_size_in, head_in[i].done=1, and every slot j<i is eligible with exc=0 and mispred=0. The prefix stops at the first non-eligible slot.
- Retire count n = length of the eligible prefix, excluding a slot with exc=1 and including a slot with mispred=1. Forced to 0 when commit_ready_in=0.
- deq_out = n. retire_valid_out[i] = (i<n) && has_dest. free_phys_out/retire_* carry the fields of slot i. Zero-destination slots still dequeue.
- Event handling in RUN, only when commit_ready_in=1:
  - First eligible mispred slot k: retire slots 0..k, latch pc_out<=target_pc[k], go to FLUSH.
  - First eligible exc slot k: retire 0..k-1, latch epc_out<=pc[k], pc_out<=EXC_VECTOR, go to FLUSH.
  - exc takes priority over mispred within the same slot.
- FLUSH (exactly 1 cycle): flush_out=1, valid_pc_out=1, deq_out=0. Load counter=RECOVER_CYCLES-1. Go to RECOVER.
- RECOVER: deq_out=0, no retires, flush_out=0. Decrement the counter; when it is 0, go to RUN the next cycle.
- Latency: retire decisions are zero-cycle (same cycle as head_in). Flush/redirect appears one cycle after the event cycle.
- Boundaries:
  - rob_size_in=0 -> n=0.
  - rob_size_in < COMMIT_WIDTH masks slots beyond size even if done.
  - No-wrap: head_in is already ordered oldest-first.
- Reset mid-FLUSH/RECOVER returns to RUN with all outputs cleared.
- Unknown/X in slots beyond rob_size_in must not affect outputs.

Test Plan:
- Reset then rob_size_in=4, all done, no events, has_dest=1 -> deq_out=4, retire_valid_out=4'b1111, no flush.
- rob_size_in=4, done=1,1,0,1 -> deq_out=2, retire_valid_out=4'b0011; slot 3 not retired.
- Slot 1 mispred, target_pc=0x2000 -> deq_out=2. Next cycle flush_out=1, valid_pc_out=1, pc_out=0x2000. Then deq_out=0 for RECOVER_CYCLES cycles, then resumes.
- Slot 2 exc, pc=0x40 -> deq_out=2, then flush with pc_out=EXC_VECTOR, epc_out=0x40. Same slot exc+mispred -> exception path.
- commit_ready_in=0 with all done plus a mispred at slot 0 -> deq_out=0, no state change. Raise ready -> event handled.
- Assert rst_in asynchronously during RECOVER -> outputs 0 immediately. After release, state RUN, next all-done head retires normally.
